uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

Parametrised UART transmit serializer; next-generation replacement for the fixed 8-bit TX shifter. Accepts words over a valid/ready handshake into a one-deep holding register and emits frames LSB-first: configurable data width, optional even/odd parity, and 1 or 2 stop bits. Runs on the system clock and advances one bit per `baud_tick` enable from the baud generator, so back-to-back frames are sent with no idle gap. Sits between the TX-side host interface and the `tx` pad.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame, legal 5..9.
- `PARITY_EN`, default 1: 1 inserts a parity bit after the data; 0 omits it.
- `STOP_BITS`, default 1: stop bits per frame, legal 1 or 2.
- `clk`  in  1  single system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `baud_tick`  in  1  one-cycle bit-period enable from the baud generator.
- `s_data`  in  DATA_WIDTH  word to transmit.
- `s_parity_odd`  in  1  parity mode for this word: 1 = odd, 0 = even. Ignored when PARITY_EN=0.
- `s_valid`  in  1  `s_data` and `s_parity_odd` are valid.
- `s_ready`  out  1  holding register is empty. Reset value 0.
- `tx`  out  1  serial line, registered, idle high. Reset value 1.
- `busy`  out  1  a frame is on the line (state not IDLE). Reset value 0.
- `done`  out  1  one-cycle pulse at the tick that ends the last stop bit. Reset value 0.

## Operation
- Frame, in order: start (0), data bits d[0]..d[DATA_WIDTH-1], optional parity, then STOP_BITS ones.
- Frame length in ticks: FRAME_LEN = 1 + DATA_WIDTH + PARITY_EN + STOP_BITS.
- Accept: on a cycle with `s_valid && s_ready`, the word and the XOR-reduced parity (inverted when `s_parity_odd`=1) are captured into the holding register.
- `s_ready` = holding register empty. It is combinational from the holding-valid flag and never depends on `s_valid`.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on `baud_tick` with the holding register full. The holding register moves into the shift register and is freed.
  - START -> DATA on tick.
  - DATA shifts one bit per tick. It moves to PARITY (PARITY_EN=1) or STOP after DATA_WIDTH ticks.
  - PARITY -> STOP on tick.
  - STOP lasts STOP_BITS ticks. At the final tick `done` pulses. The next state is START if the holding register is full (reload, no gap); otherwise it is IDLE.
- With no `baud_tick`, state, counters and `tx` hold.
- Bit counter width is $clog2(DATA_WIDTH+1). It reloads at each state entry and never wraps within a state.

## Timing
- `tx` changes only on the clock edge at which `baud_tick`=1. Each bit holds for exactly one tick period.
- Latency: word accepted in cycle N, FSM idle. The start bit appears on `tx` the cycle after the first `baud_tick` at or after N+1.
- `s_ready` rises the cycle after the holding register is drained.
- Holding register full: `s_ready`=0. A new word can be accepted while a frame is in progress, which gives double buffering.
- A `s_valid` arriving in the same cycle as a drain tick is not accepted that cycle. It is accepted the next cycle.
- Reset asserted mid-frame:
  - Immediately `tx`=1, `busy`=0, `done`=0, `s_ready`=0, and the holding register is cleared.
  - After release, `s_ready`=1 from the first clock edge. No partial frame resumes.
- `done` and `busy` are registered. `busy` falls in the same cycle `tx` returns to idle after the last stop bit, unless a reload occurs; on a reload `busy` stays high.

## Structure
- Shared package `uart_pkg`:
  - state enum `uart_tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - parity-mode constants;
  - function `uart_frame_len(DATA_WIDTH, PARITY_EN, STOP_BITS)`, also used by the RX block.
- One sub-module is natural: `uart_tx_hold_reg`, the one-entry holding register. It owns the valid/ready handshake and parity computation, and presents `{parity, data}` plus a full flag to the FSM.
- Parameter legality is checked by elaboration-time assertions.

## Test plan
- 8/1/1, even, `s_data`=0xA5, tick every 16 clocks -> `tx` = 0,1,0,1,0,0,1,0,1,0,1, each bit 16 clocks wide; one `done` pulse; `busy` high for 11 ticks.
- Odd parity, `s_data`=0x00 -> parity bit 1. Even parity, 0x01 -> parity bit 1. Even parity, 0xFF -> parity bit 0.
- Back-to-back 0x55 then 0x0F, second word offered while the first frame is in DATA -> second start bit directly follows the first stop bit; `s_ready` low from the second accept until reload; two `done` pulses 11 ticks apart.
- DATA_WIDTH=7, PARITY_EN=0, STOP_BITS=2, `s_data`=0x41 -> `tx` = 0,1,0,0,0,0,0,1,1,1 (10 ticks).
- Hold `baud_tick` low for 100 clocks mid-DATA -> `tx` and state frozen; the frame resumes correctly on the next tick.
- Assert `reset` during bit 4 with a word held -> `tx`=1 and `s_ready`=0 in the same cycle; after release the line stays idle and `s_ready`=1 with no stale frame sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Purpose: shared UART types, parity-mode constants and frame-length helper (TX and RX).
// Latency: n/a, definitions only.
// Backpressure: n/a.
package uart_pkg;

  // Serializer frame phases.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  // Per-word parity mode as carried on s_parity_odd.
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Bit periods in one frame: start + data + optional parity + stop bits.
  function automatic int unsigned uart_frame_len(input int unsigned data_width,
                                                 input int unsigned parity_en,
                                                 input int unsigned stop_bits);
    return 1 + data_width + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_hold_reg.sv
// Purpose: one-entry holding register in front of the TX serializer; captures {parity, data}.
// Latency: word visible to the FSM the cycle after s_valid && s_ready.
// Backpressure: s_ready low while full; freed by drain_i, s_ready rises the cycle after.
//
// Ports: clk/reset (async, active high); s_data/s_parity_odd/s_valid/s_ready host handshake;
//        drain_i from the FSM when it loads the shift register; full_o and hold_o = {parity, data}.
module uart_tx_hold_reg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_parity_odd,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  drain_i,
  output logic                  full_o,
  output logic [DATA_WIDTH:0]   hold_o
);

  logic                rdy_en_q;
  logic                vld_q, vld_d;
  logic [DATA_WIDTH:0] dat_q, dat_d;
  logic                par;
  logic                accept;

  // Even parity is the plain XOR of the data; odd inverts it.
  assign par     = (^s_data) ^ (s_parity_odd == PARITY_ODD);
  // rdy_en_q keeps s_ready low while reset is asserted even though the register is empty.
  assign s_ready = rdy_en_q & ~vld_q;
  assign accept  = s_valid & s_ready;
  assign full_o  = vld_q;
  assign hold_o  = dat_q;

  // drain_i only fires while full, when s_ready is already low, so it never
  // collides with an accept in the same cycle.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (drain_i) begin
      vld_d = 1'b0;
    end else if (accept) begin
      vld_d = 1'b1;
      dat_d = {par, s_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_en_q <= 1'b0;
      vld_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      vld_q    <= vld_d;
      dat_q    <= dat_d;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// Purpose: parametrised UART TX serializer, LSB first, optional parity, 1 or 2 stop bits.
// Latency: start bit on tx the cycle after the first baud_tick following the accept.
// Backpressure: one-deep holding register; s_ready low while it holds a word.
//
// Ports: clk, reset (async, active high), baud_tick (bit-period enable);
//        s_data/s_parity_odd/s_valid/s_ready word input handshake;
//        tx (registered, idle high), busy (frame on line), done (pulse at end of last stop bit).
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  baud_tick,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_parity_odd,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data_width
    $error("uart_tx_serializer: DATA_WIDTH must be in 5..9");
  end
  if (PARITY_EN > 1) begin : g_bad_parity_en
    $error("uart_tx_serializer: PARITY_EN must be 0 or 1");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end

  localparam int unsigned     CNT_W     = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

  uart_tx_state_t      state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH:0] shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                hold_full;
  logic [DATA_WIDTH:0] hold_dat;
  logic                drain;

  uart_tx_hold_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_hold (
    .clk          (clk),
    .reset        (reset),
    .s_data       (s_data),
    .s_parity_odd (s_parity_odd),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .drain_i      (drain),
    .full_o       (hold_full),
    .hold_o       (hold_dat)
  );

  // The shift register carries {parity, data}; after the data bits have been
  // shifted out the parity bit sits at position 0 ready for the PARITY state.
  // cnt_q counts the bits still to go in the current state after the one on the line.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    drain   = 1'b0;
    if (baud_tick) begin
      case (state_q)
        IDLE: begin
          if (hold_full) begin
            state_d = START;
            cnt_d   = '0;
            shift_d = hold_dat;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
            drain   = 1'b1;
          end
        end
        START: begin
          state_d = DATA;
          cnt_d   = DATA_LAST;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
        DATA: begin
          if (cnt_q == '0) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              cnt_d   = '0;
              tx_d    = shift_q[0];
            end else begin
              state_d = STOP;
              cnt_d   = STOP_LAST;
              tx_d    = 1'b1;
            end
          end else begin
            cnt_d   = cnt_q - CNT_W'(1);
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
        PARITY: begin
          state_d = STOP;
          cnt_d   = STOP_LAST;
          tx_d    = 1'b1;
        end
        STOP: begin
          if (cnt_q == '0) begin
            done_d = 1'b1;
            // Reload straight into the next start bit when a word is waiting.
            if (hold_full) begin
              state_d = START;
              cnt_d   = '0;
              shift_d = hold_dat;
              tx_d    = 1'b0;
              drain   = 1'b1;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
              busy_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Purpose: self-checking bench for uart_tx_serializer in 8/1/1 and 7/0/2 configurations.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_serializer;
  import uart_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       baud_tick;
  logic [7:0] sd0;
  logic [6:0] sd1;
  logic [1:0] sv, sodd;
  logic       srdy0, srdy1, tx0, tx1, busy0, busy1, done0, done1;

  uart_tx_serializer #(.DATA_WIDTH(8), .PARITY_EN(1), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .s_data(sd0), .s_parity_odd(sodd[0]),
    .s_valid(sv[0]), .s_ready(srdy0), .tx(tx0), .busy(busy0), .done(done0));

  uart_tx_serializer #(.DATA_WIDTH(7), .PARITY_EN(0), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .s_data(sd1), .s_parity_odd(sodd[1]),
    .s_valid(sv[1]), .s_ready(srdy1), .tx(tx1), .busy(busy1), .done(done1));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model (bit-stream level) ----------------
  int          cfg_dw[2]  = '{8, 7};
  int          cfg_pen[2] = '{1, 0};
  int          cfg_nst[2] = '{1, 2};
  logic [1:0]  m_pend, m_act, m_tx, m_busy, m_done;
  logic [8:0]  m_pdat[2];
  logic        m_podd[2];
  logic [15:0] m_frame[2];
  int          m_pos[2];
  logic        m_rdy_en;
  logic        m_ticked;
  int          acc_cnt[2] = '{0, 0};
  int          tick_cnt = 0;

  // Line bits of one frame in transmission order: bit i is the i-th bit period.
  function automatic logic [15:0] build_frame(input int dw, input int pen, input logic [8:0] data,
                                              input logic odd);
    logic [15:0] f;
    int ones;
    f = '1;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < dw; i++) begin
      f[1+i] = data[i];
      ones += int'(data[i]);
    end
    if (pen != 0) f[1+dw] = ((ones % 2) == 1) ^ odd;
    return f;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_act = '0; m_tx = '1; m_busy = '0; m_done = '0;
    m_rdy_en = 1'b0; m_ticked = 1'b0;
  endtask

  task automatic model_step();
    logic [1:0] acc;
    int len;
    m_ticked = baud_tick;
    for (int d = 0; d < 2; d++) begin
      acc[d] = sv[d] && m_rdy_en && !m_pend[d];
      m_done[d] = 1'b0;
      if (baud_tick) begin
        len = int'(uart_frame_len(cfg_dw[d], cfg_pen[d], cfg_nst[d]));
        if (m_act[d] && m_pos[d] == len) begin
          m_done[d] = 1'b1;
          m_act[d]  = 1'b0;
        end
        if (!m_act[d] && m_pend[d]) begin
          m_frame[d] = build_frame(cfg_dw[d], cfg_pen[d], m_pdat[d], m_podd[d]);
          m_pos[d]   = 0;
          m_act[d]   = 1'b1;
          m_pend[d]  = 1'b0;
        end
        if (m_act[d]) begin
          m_tx[d] = m_frame[d][m_pos[d]];
          m_pos[d]++;
        end else begin
          m_tx[d] = 1'b1;
        end
        m_busy[d] = m_act[d];
      end
      if (acc[d]) begin
        m_pend[d] = 1'b1;
        m_pdat[d] = (d == 0) ? {1'b0, sd0} : {2'b00, sd1};
        m_podd[d] = sodd[d];
        acc_cnt[d]++;
      end
    end
    if (baud_tick) tick_cnt++;
    m_rdy_en = 1'b1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle comparison and capture ----------------
  bit cap0[$];
  bit cap1[$];
  int done_t0[$];

  initial begin
    forever begin
      @(negedge clk);
      chk("tx0",    tx0,   m_tx[0]);
      chk("busy0",  busy0, m_busy[0]);
      chk("done0",  done0, m_done[0]);
      chk("ready0", srdy0, m_rdy_en & ~m_pend[0]);
      chk("tx1",    tx1,   m_tx[1]);
      chk("busy1",  busy1, m_busy[1]);
      chk("done1",  done1, m_done[1]);
      chk("ready1", srdy1, m_rdy_en & ~m_pend[1]);
      if (m_ticked && m_busy[0]) cap0.push_back(tx0);
      if (m_ticked && m_busy[1]) cap1.push_back(tx1);
      if (done0) done_t0.push_back(tick_cnt);
    end
  end

  // ---------------- baud tick generator ----------------
  int tick_mode = 0;    // 0 off, 1 periodic, 2 random
  int tick_period = 16;
  int tcnt;

  initial begin
    baud_tick = 1'b0;
    tcnt = 0;
    forever begin
      @(negedge clk);
      case (tick_mode)
        1: begin
          tcnt = (tcnt + 1 >= tick_period) ? 0 : tcnt + 1;
          baud_tick = (tcnt == 0);
        end
        2: baud_tick = ($urandom_range(0, 3) == 0);
        default: begin
          tcnt = 0;
          baud_tick = 1'b0;
        end
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  int exp_bits[$];

  task automatic send(input int d, input logic [8:0] data, input logic odd);
    int start;
    bit ok;
    start = acc_cnt[d];
    ok = 1'b0;
    @(negedge clk);
    if (d == 0) sd0 = data[7:0];
    else sd1 = data[6:0];
    sodd[d] = odd;
    sv[d] = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (acc_cnt[d] != start) begin
        ok = 1'b1;
        break;
      end
    end
    sv[d] = 1'b0;
    chk("send_accept", ok, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (m_act == 2'b00 && m_pend == 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", ok, 1);
  endtask

  task automatic wait_cap0(input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (cap0.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    chk("cap_timeout", ok, 1);
  endtask

  task automatic cmp_cap(input int d, input string tag);
    int n;
    n = (d == 0) ? cap0.size() : cap1.size();
    chk({tag, "_len"}, n, exp_bits.size());
    for (int i = 0; i < exp_bits.size(); i++)
      chk(tag, (d == 0) ? cap0[i] : cap1[i], exp_bits[i]);
  endtask

  logic [8:0] par_dat[3] = '{9'h000, 9'h001, 9'h0FF};
  logic       par_odd[3] = '{1'b1, 1'b0, 1'b0};
  logic       par_exp[3] = '{1'b1, 1'b1, 1'b0};

  // ---------------- main sequence ----------------
  initial begin
    int zeros;
    reset = 1'b1;
    sv = '0; sodd = '0; sd0 = '0; sd1 = '0;
    #1;
    chk("rst_tx",    tx0,   1);
    chk("rst_ready", srdy0, 0);
    chk("rst_busy",  busy0, 0);
    chk("rst_done",  done0, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rel_ready0", srdy0, 1);
    chk("rel_ready1", srdy1, 1);

    // 8/1/1 even 0xA5, tick every 16 clocks.
    tick_mode = 1; tick_period = 16;
    cap0.delete(); done_t0.delete();
    send(0, 9'h0A5, 1'b0);
    wait_idle();
    exp_bits = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
    cmp_cap(0, "a5");
    chk("a5_done_cnt", done_t0.size(), 1);

    // Parity bit for odd 0x00, even 0x01, even 0xFF.
    tick_period = 2;
    for (int k = 0; k < 3; k++) begin
      cap0.delete();
      send(0, par_dat[k], par_odd[k]);
      wait_idle();
      chk("par_len", cap0.size(), 11);
      chk("par_bit", cap0[9], par_exp[k]);
    end

    // Back-to-back: second word offered while the first frame is in DATA.
    cap0.delete(); done_t0.delete();
    send(0, 9'h055, 1'b0);
    wait_cap0(3);
    send(0, 9'h00F, 1'b0);
    wait_idle();
    chk("b2b_len", cap0.size(), 22);
    chk("b2b_start2", cap0[11], 0);
    chk("b2b_dones", done_t0.size(), 2);
    chk("b2b_gap", done_t0[1] - done_t0[0], 11);

    // 7/0/2 with 0x41.
    cap1.delete();
    send(1, 9'h041, 1'b0);
    wait_idle();
    exp_bits = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 1};
    cmp_cap(1, "w7");

    // Tick stalled for 100 clocks mid-DATA.
    cap0.delete();
    send(0, 9'h096, 1'b0);
    wait_cap0(4);
    tick_mode = 0;
    repeat (100) @(negedge clk);
    chk("frz_busy", busy0, 1);
    tick_mode = 1;
    wait_idle();
    exp_bits = '{0, 0, 1, 1, 0, 1, 0, 0, 1, 0, 1};
    cmp_cap(0, "frz");

    // Reset mid-frame with a second word waiting in the holding register.
    tick_period = 4;
    cap0.delete();
    send(0, 9'h03C, 1'b1);
    send(0, 9'h0C3, 1'b0);
    wait_cap0(5);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_tx",    tx0,   1);
    chk("mid_rst_ready", srdy0, 0);
    chk("mid_rst_busy",  busy0, 0);
    chk("mid_rst_done",  done0, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rel_ready", srdy0, 1);
    zeros = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx0 == 1'b0 || busy0 == 1'b1) zeros++;
    end
    chk("no_stale_frame", zeros, 0);

    // Random traffic on both instances with random tick spacing.
    tick_mode = 2;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      sv[0] = ($urandom_range(0, 2) != 0);
      sv[1] = ($urandom_range(0, 2) != 0);
      sd0 = 8'($urandom);
      sd1 = 7'($urandom);
      sodd = 2'($urandom);
    end
    sv = '0;
    wait_idle();
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
